// File: rtl/wisc_pkg.sv
// Shared definitions for the WISC core: opcodes, default widths, halt FSM states
// and the opcode-to-flag-class mapping used by the execute/memory boundary.
package wisc_pkg;

    localparam int DW_DEF = 16;
    localparam int RW_DEF = 4;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } halt_state_e;

    // Returns {updates_nzv, updates_z_only}; RED and PADDSB deliberately leave flags alone.
    function automatic logic [1:0] flag_class(input logic [3:0] op);
        logic [1:0] cls;
        cls = 2'b00;
        case (op)
            OP_ADD, OP_SUB:                 cls = 2'b10;
            OP_XOR, OP_SLL, OP_SRA, OP_ROR: cls = 2'b01;
            default:                        cls = 2'b00;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/flag_reg.sv
// Architectural N/Z/V flag register with an independent load enable per bit.
module flag_reg (
    input  logic clk,
    input  logic rst,
    input  logic en_n,
    input  logic en_z,
    input  logic en_v,
    input  logic n_d,
    input  logic z_d,
    input  logic v_d,
    output logic flag_n,
    output logic flag_z,
    output logic flag_v
);

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
        end else begin
            if (en_n) flag_n <= n_d;
            if (en_z) flag_z <= z_d;
            if (en_v) flag_v <= v_d;
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register of the WISC core: captures ALU results and control,
// owns the flag register, the EX-to-EX forwarding tap and sticky halt tracking.
module ex_mem_reg
    import wisc_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [3:0]    ex_opcode,
    input  logic [DW-1:0] ex_result,
    input  logic          ex_ovfl,
    input  logic [DW-1:0] ex_store_data,
    input  logic [RW-1:0] ex_dst,
    input  logic          ex_wr_en,
    input  logic          stall,
    input  logic          flush,
    output logic          mem_valid,
    output logic [3:0]    mem_opcode,
    output logic [DW-1:0] mem_result,
    output logic [DW-1:0] mem_store_data,
    output logic [RW-1:0] mem_dst,
    output logic          mem_wr_en,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic          flag_n,
    output logic          flag_z,
    output logic          flag_v,
    output logic          fwd_valid,
    output logic [RW-1:0] fwd_dst,
    output logic [DW-1:0] fwd_data,
    output logic          halted
);

    halt_state_e state, state_nxt;
    logic        accept;
    logic [1:0]  cls;
    logic        en_nzv;
    logic        en_z;

    assign halted = (state == ST_HALTED);
    assign accept = ex_valid & ~stall & ~flush & ~halted;

    always_comb begin
        state_nxt = state;
        if (state == ST_RUN && accept && ex_opcode == OP_HLT)
            state_nxt = ST_HALTED;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_RUN;
        else     state <= state_nxt;
    end

    // EX -> MEM stage boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid      <= 1'b0;
            mem_opcode     <= 4'h0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_dst        <= '0;
            mem_wr_en      <= 1'b0;
            mem_rd         <= 1'b0;
            mem_wr         <= 1'b0;
        end else if (halted || flush) begin
            // Bubble: control cleared, data fields keep their last values.
            mem_valid <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else if (!stall) begin
            mem_valid      <= ex_valid;
            mem_opcode     <= ex_opcode;
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_dst        <= ex_dst;
            mem_wr_en      <= ex_valid & ex_wr_en;
            mem_rd         <= ex_valid & (ex_opcode == OP_LW);
            mem_wr         <= ex_valid & (ex_opcode == OP_SW);
        end
    end

    assign cls    = flag_class(ex_opcode);
    assign en_nzv = accept & cls[1];
    assign en_z   = accept & (cls[1] | cls[0]);

    flag_reg u_flags (
        .clk    (clk),
        .rst    (rst),
        .en_n   (en_nzv),
        .en_z   (en_z),
        .en_v   (en_nzv),
        .n_d    (ex_result[DW-1]),
        .z_d    (ex_result == '0),
        .v_d    (ex_ovfl),
        .flag_n (flag_n),
        .flag_z (flag_z),
        .flag_v (flag_v)
    );

    // Register 0 is hardwired, so a write to it must never be bypassed.
    assign fwd_valid = mem_valid & mem_wr_en & (mem_dst != '0);
    assign fwd_dst   = mem_dst;
    assign fwd_data  = mem_result;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: directed vectors push hand-computed expected
// stage outputs; a negedge monitor pops and compares them one cycle later.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_result;
    logic        ex_ovfl;
    logic [15:0] ex_store_data;
    logic [3:0]  ex_dst;
    logic        ex_wr_en;
    logic        stall;
    logic        flush;
    logic        mem_valid;
    logic [3:0]  mem_opcode;
    logic [15:0] mem_result;
    logic [15:0] mem_store_data;
    logic [3:0]  mem_dst;
    logic        mem_wr_en, mem_rd, mem_wr;
    logic        flag_n, flag_z, flag_v;
    logic        fwd_valid;
    logic [3:0]  fwd_dst;
    logic [15:0] fwd_data;
    logic        halted;

    typedef struct packed {
        logic        valid;
        logic [3:0]  op;
        logic [15:0] res;
        logic [15:0] sd;
        logic [3:0]  dst;
        logic        we, rd, wr;
        logic        n, z, v;
        logic        fv;
        logic [3:0]  fdst;
        logic [15:0] fdata;
        logic        halted;
    } out_t;

    typedef struct {
        string name;
        out_t  exp;
    } sb_t;

    sb_t q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.DW(16), .RW(4)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
        .ex_result(ex_result), .ex_ovfl(ex_ovfl), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_wr_en(ex_wr_en), .stall(stall), .flush(flush),
        .mem_valid(mem_valid), .mem_opcode(mem_opcode), .mem_result(mem_result),
        .mem_store_data(mem_store_data), .mem_dst(mem_dst), .mem_wr_en(mem_wr_en),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .flag_n(flag_n), .flag_z(flag_z),
        .flag_v(flag_v), .fwd_valid(fwd_valid), .fwd_dst(fwd_dst),
        .fwd_data(fwd_data), .halted(halted)
    );

    function automatic out_t mk(input logic valid, input logic [3:0] op,
                                input logic [15:0] res, input logic [15:0] sd,
                                input logic [3:0] dst, input logic we, rd, wr,
                                input logic n, z, v, fv, h);
        out_t e;
        e.valid = valid; e.op = op; e.res = res; e.sd = sd; e.dst = dst;
        e.we = we; e.rd = rd; e.wr = wr; e.n = n; e.z = z; e.v = v;
        e.fv = fv; e.fdst = dst; e.fdata = res; e.halted = h;
        return e;
    endfunction

    task automatic vec(input string nm, input logic r, v, input logic [3:0] op,
                       input logic [15:0] res, input logic ov, input logic [15:0] sd,
                       input logic [3:0] dst, input logic we, st, fl, input out_t e);
        sb_t s;
        @(negedge clk);
        #1;
        rst = r; ex_valid = v; ex_opcode = op; ex_result = res; ex_ovfl = ov;
        ex_store_data = sd; ex_dst = dst; ex_wr_en = we; stall = st; flush = fl;
        s.name = nm;
        s.exp  = e;
        q.push_back(s);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            sb_t  s;
            out_t a;
            s = q.pop_front();
            a.valid = mem_valid; a.op = mem_opcode; a.res = mem_result;
            a.sd = mem_store_data; a.dst = mem_dst; a.we = mem_wr_en;
            a.rd = mem_rd; a.wr = mem_wr; a.n = flag_n; a.z = flag_z;
            a.v = flag_v; a.fv = fwd_valid; a.fdst = fwd_dst;
            a.fdata = fwd_data; a.halted = halted;
            n_cmp++;
            if (a !== s.exp) begin
                n_bad++;
                $display("FAIL %s: got %h, expected %h", s.name, a, s.exp);
            end
        end
    end

    initial begin
        rst = 1'b1; ex_valid = 1'b0; ex_opcode = 4'h0; ex_result = 16'h0;
        ex_ovfl = 1'b0; ex_store_data = 16'h0; ex_dst = 4'h0; ex_wr_en = 1'b0;
        stall = 1'b0; flush = 1'b0;

        // name            rst v  op     result     ov sdata      dst  we st fl   expected: v op res sd dst we rd wr n z v fv h
        vec("reset0",      1, 1, 4'h0, 16'($urandom), 1, 16'($urandom), 4'd3, 1, 0, 0, mk(0,4'h0,16'h0000,16'h0000,4'd0,0,0,0,0,0,0,0,0));
        vec("reset1",      1, 1, 4'hF, 16'($urandom), 1, 16'($urandom), 4'd7, 1, 1, 0, mk(0,4'h0,16'h0000,16'h0000,4'd0,0,0,0,0,0,0,0,0));
        vec("add_zero_ov", 0, 1, 4'h0, 16'h0000, 1, 16'h1111, 4'd1, 1, 0, 0, mk(1,4'h0,16'h0000,16'h1111,4'd1,1,0,0,0,1,1,1,0));
        vec("red_noflag",  0, 1, 4'h3, 16'h0028, 0, 16'h0000, 4'd2, 1, 0, 0, mk(1,4'h3,16'h0028,16'h0000,4'd2,1,0,0,0,1,1,1,0));
        vec("sub_neg",     0, 1, 4'h1, 16'h8000, 0, 16'h0000, 4'd3, 1, 0, 0, mk(1,4'h1,16'h8000,16'h0000,4'd3,1,0,0,1,0,0,1,0));
        vec("xor_zonly",   0, 1, 4'h2, 16'h0000, 1, 16'h0000, 4'd4, 1, 0, 0, mk(1,4'h2,16'h0000,16'h0000,4'd4,1,0,0,1,1,0,1,0));
        vec("paddsb_nofl", 0, 1, 4'h7, 16'h7F7F, 1, 16'h0000, 4'd6, 1, 0, 0, mk(1,4'h7,16'h7F7F,16'h0000,4'd6,1,0,0,1,1,0,1,0));
        vec("add_dst5",    0, 1, 4'h0, 16'h000F, 0, 16'h2222, 4'd5, 1, 0, 0, mk(1,4'h0,16'h000F,16'h2222,4'd5,1,0,0,0,0,0,1,0));
        vec("stall1",      0, 1, 4'h1, 16'h0000, 1, 16'h3333, 4'd7, 1, 1, 0, mk(1,4'h0,16'h000F,16'h2222,4'd5,1,0,0,0,0,0,1,0));
        vec("stall2",      0, 1, 4'h8, 16'h0040, 0, 16'h3434, 4'd9, 1, 1, 0, mk(1,4'h0,16'h000F,16'h2222,4'd5,1,0,0,0,0,0,1,0));
        vec("stall_hlt",   0, 1, 4'hF, 16'h0000, 0, 16'h0000, 4'd0, 0, 1, 0, mk(1,4'h0,16'h000F,16'h2222,4'd5,1,0,0,0,0,0,1,0));
        vec("stall_flush", 0, 1, 4'h0, 16'h0000, 1, 16'h9999, 4'd8, 1, 1, 1, mk(0,4'h0,16'h000F,16'h2222,4'd5,0,0,0,0,0,0,0,0));
        vec("lw_r0",       0, 1, 4'h8, 16'h0040, 0, 16'h4444, 4'd0, 1, 0, 0, mk(1,4'h8,16'h0040,16'h4444,4'd0,1,1,0,0,0,0,0,0));
        vec("sw",          0, 1, 4'h9, 16'h0042, 0, 16'h5555, 4'd9, 0, 0, 0, mk(1,4'h9,16'h0042,16'h5555,4'd9,0,0,1,0,0,0,0,0));
        vec("invalid_add", 0, 0, 4'h0, 16'h0000, 1, 16'h6666, 4'd10,1, 0, 0, mk(0,4'h0,16'h0000,16'h6666,4'd10,0,0,0,0,0,0,0,0));
        vec("hlt_accept",  0, 1, 4'hF, 16'h0000, 0, 16'h0000, 4'd0, 0, 0, 0, mk(1,4'hF,16'h0000,16'h0000,4'd0,0,0,0,0,0,0,0,1));
        vec("halted_add",  0, 1, 4'h0, 16'h0000, 1, 16'h1234, 4'd1, 1, 0, 0, mk(0,4'hF,16'h0000,16'h0000,4'd0,0,0,0,0,0,0,0,1));
        vec("halted_sub",  0, 1, 4'h1, 16'h8000, 1, 16'h4321, 4'd2, 1, 0, 0, mk(0,4'hF,16'h0000,16'h0000,4'd0,0,0,0,0,0,0,0,1));
        vec("rst_halted",  1, 1, 4'h0, 16'h8001, 1, 16'h7777, 4'd2, 1, 1, 0, mk(0,4'h0,16'h0000,16'h0000,4'd0,0,0,0,0,0,0,0,0));
        vec("resume_add",  0, 1, 4'h0, 16'h8001, 1, 16'h7777, 4'd2, 1, 0, 0, mk(1,4'h0,16'h8001,16'h7777,4'd2,1,0,0,1,0,1,1,0));
        vec("bubble_in",   0, 0, 4'h2, 16'h0000, 0, 16'h0000, 4'd3, 1, 0, 0, mk(0,4'h2,16'h0000,16'h0000,4'd3,0,0,0,1,0,1,0,0));

        for (int i = 0; i < 10 && q.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_mem_reg.md
# ex_mem_reg

Execute-to-memory pipeline stage of the 16-bit WISC core. It sits directly downstream of the execute-stage ALU, including the RED reduction unit, and captures its result plus control each cycle. It also owns the N/Z/V flag register, the forwarding tap for the EX-to-EX bypass, and halt tracking. Stall, flush and halt determine what the memory stage sees.

## Interface
Parameters:
- DW, 16, datapath width
- RW, 4, register-index width

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- ex_valid  in  1  EX holds a real instruction this cycle
- ex_opcode  in  4  instruction opcode
- ex_result  in  DW  ALU/RED result, or address for LW/SW
- ex_ovfl  in  1  ALU signed overflow for ADD/SUB
- ex_store_data  in  DW  store data for SW
- ex_dst  in  RW  destination register
- ex_wr_en  in  1  instruction writes the register file
- stall  in  1  hold stage contents
- flush  in  1  squash instruction entering this cycle
- mem_valid  out  1  registered valid
- mem_opcode  out  4  registered opcode
- mem_result  out  DW  registered result/address
- mem_store_data  out  DW  registered store data
- mem_dst  out  RW  registered destination
- mem_wr_en  out  1  registered write enable, gated by valid
- mem_rd  out  1  registered, true for LW
- mem_wr  out  1  registered, true for SW
- flag_n, flag_z, flag_v  out  1 each  architectural flags
- fwd_valid  out  1  mem_valid & mem_wr_en & (mem_dst != 0)
- fwd_dst  out  RW  equals mem_dst
- fwd_data  out  DW  equals mem_result
- halted  out  1  sticky; a HLT has committed

## Operation
- Opcodes: ADD 0, SUB 1, XOR 2, RED 3, SLL 4, SRA 5, ROR 6, PADDSB 7, LW 8, SW 9, LLB A, LHB B, B C, BR D, PCS E, HLT F.
- Capture: if not halted and not stall, all mem_* load from ex_*. mem_valid loads ex_valid & ~flush.
- Flush priority: flush overrides stall. The stage loads a bubble with mem_valid=0 and mem_wr_en=mem_rd=mem_wr=0. Data fields are don't-care but are held.
- Stall without flush: every mem_* output and every flag holds.
- Flags update only on an accepted valid instruction (ex_valid & ~stall & ~flush & ~halted), at the same edge as capture:
  - ADD, SUB: N=ex_result[15], Z=(ex_result==0), V=ex_ovfl
  - XOR, SLL, SRA, ROR: Z only
  - all other opcodes, including RED and PADDSB: no flag change
- State machine:
  - RUN: normal capture.
  - RUN→HALTED on accepted HLT. The HLT is itself captured with mem_valid=1.
  - HALTED: mem_valid forced to 0 from the next edge onward; inputs ignored; flags frozen.
  - Exit HALTED only via rst.
- mem_rd and mem_wr are decoded from ex_opcode at capture and gated by the captured valid.

## Timing
- Latency is 1 cycle, ex_* to mem_*. Forwarding outputs are combinational from registered state, so they add no cycle.
- Reset, synchronous on the rst edge: all mem_* = 0, flags N=Z=V=0, halted=0, state RUN, fwd_valid=0. rst wins over stall, flush and HLT in the same cycle.
- Reset mid-stall or while HALTED returns to RUN at the next edge. Capture resumes on the following edge.
- stall & flush in the same cycle produces a bubble (flush wins).
- HLT arriving together with stall is not accepted, so the stage stays in RUN. It is accepted on the first non-stalled cycle.
- Back-to-back flag writers: each edge applies only the accepted instruction's rule. There is no accumulation.

## Structure
- Shared package wisc_pkg holds:
  - opcode localparams
  - DW/RW defaults
  - the flag-class function mapping opcode to {updates_nzv, updates_z_only}
- One sub-module, flag_reg: NZV register with per-bit enables, reset to 0.
- The top level contains the pipeline register, the 2-state halt FSM and the forwarding assigns.

## Test plan
- Reset: drive random inputs with rst=1 for 2 cycles -> all outputs 0, halted=0.
- ADD then RED:
  - ADD result 0x0000 with ex_ovfl=1 -> next cycle flag_z=1, flag_v=1, flag_n=0, mem_result=0x0000.
  - Then RED result 0x0028 -> mem_result=0x0028, flags unchanged (Z=1, V=1).
- XOR:
  - SUB result 0x8000 -> N=1, Z=0.
  - Then XOR result 0x0000 -> Z=1, N stays 1.
- Stall/flush:
  - Capture ADD dst=5 result 0x000F, then stall 3 cycles with new inputs -> mem_result holds 0x000F, fwd_valid=1, fwd_dst=5.
  - Then stall & flush -> mem_valid=0, fwd_valid=0, flags unchanged.
- Register-0 write: LW dst=0 -> mem_rd=1, fwd_valid=0.
- Halt:
  - HLT accepted -> mem_valid=1 for one cycle, halted=1.
  - Subsequent ADD result 0x0000 -> mem_valid stays 0, flags frozen.
  - rst -> halted=0 and capture resumes.
